// File: rtl/sd_host_regs_pkg.sv
// Shared register map, bit positions and read constants for the SD host register bank.
package sd_host_regs_pkg;

  localparam logic [4:0] ADR_ARGUMENT          = 5'd0;
  localparam logic [4:0] ADR_COMMAND           = 5'd1;
  localparam logic [4:0] ADR_BLOCK             = 5'd2;
  localparam logic [4:0] ADR_PRESENT_STATE     = 5'd3;
  localparam logic [4:0] ADR_RESPONSE0         = 5'd4;
  localparam logic [4:0] ADR_RESPONSE1         = 5'd5;
  localparam logic [4:0] ADR_RESPONSE2         = 5'd6;
  localparam logic [4:0] ADR_RESPONSE3         = 5'd7;
  localparam logic [4:0] ADR_HOST_CONTROL      = 5'd8;
  localparam logic [4:0] ADR_CLOCK_CONTROL     = 5'd9;
  localparam logic [4:0] ADR_SOFTWARE_RESET    = 5'd10;
  localparam logic [4:0] ADR_NORMAL_INT_STATUS = 5'd12;
  localparam logic [4:0] ADR_ERROR_INT_STATUS  = 5'd13;
  localparam logic [4:0] ADR_INT_ENABLE        = 5'd14;
  localparam logic [4:0] ADR_CAPABILITIES      = 5'd15;

  localparam int CMD_INHIBIT_BIT      = 0;
  localparam int NIS_CMD_COMPLETE_BIT = 0;
  localparam int NIS_ERROR_BIT        = 15;

  localparam logic [31:0] BLOCK_WR_MASK   = 32'hFFFF_0FFF;
  localparam logic [31:0] RESERVED_RD_VAL = 32'h0000_0000;

endpackage

// File: rtl/sd_w1c_status16.sv
// 16-bit sticky status: level sources OR-set each edge, write-1-to-clear, set beats clear.
// Latency: new state visible one cycle after the set/clear edge.
// Backpressure: none; set, clear and soft clear are accepted every cycle.
module sd_w1c_status16 (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] set_vec,
  input  logic [15:0] clr_vec,
  input  logic        sw_clr,
  output logic [15:0] status
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      status <= 16'h0000;
    end else if (sw_clr) begin
      status <= 16'h0000;
    end else begin
      status <= (status & ~clr_vec) | set_vec;
    end
  end

endmodule

// File: rtl/sd_host_register_bank.sv
// SD host register bank: address decode, single-cycle writes, response capture, sticky interrupts.
// Latency: writes take effect on the strobe edge; reads return data_o/read_valid_o one cycle later.
// Backpressure: none; a COMMAND write while a command is in flight is silently dropped.
module sd_host_register_bank
  import sd_host_regs_pkg::*;
#(
  parameter logic [31:0] CAPABILITIES = 32'h0000_0001,
  parameter int          NUM_REGS     = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [4:0]   adr_i,
  input  logic         reg_write_en,
  input  logic         reg_read_en,
  input  logic         command_complete,
  input  logic [127:0] data_i,
  input  logic [127:0] response_i,
  input  logic [15:0]  error_interrupt_status_i,
  input  logic [15:0]  normal_interrupt_status_i,
  output logic [31:0]  data_o,
  output logic         read_valid_o,
  output logic         cmd_start_o,
  output logic [31:0]  argument_o,
  output logic [15:0]  command_o,
  output logic         interrupt_o
);

  logic [31:0]  wr_dat;
  logic         unused_data_hi;
  logic         adr_impl;
  logic         wr_vld;
  logic         cmd_complete_q;
  logic         cmd_rise;
  logic         cmd_inhibit_q;
  logic         cmd_accept;
  logic         sw_reset;
  logic [31:0]  block_q;
  logic [7:0]   host_ctrl_q;
  logic [15:0]  clk_ctrl_q;
  logic [31:0]  int_en_q;
  logic [127:0] resp_q;
  logic [15:0]  nis_q;
  logic [15:0]  eis_q;
  logic [15:0]  nis_rd;
  logic [15:0]  nis_set;
  logic [15:0]  nis_clr;
  logic [15:0]  eis_clr;
  logic [31:0]  present_state;
  logic [31:0]  rd_dat;

  assign wr_dat         = data_i[31:0];
  assign unused_data_hi = ^data_i[127:32];
  assign adr_impl       = (adr_i < 5'(NUM_REGS));
  assign wr_vld         = reg_write_en && adr_impl;
  assign cmd_rise       = command_complete && !cmd_complete_q;
  assign cmd_accept     = wr_vld && (adr_i == ADR_COMMAND) && !cmd_inhibit_q;
  assign sw_reset       = wr_vld && (adr_i == ADR_SOFTWARE_RESET) && wr_dat[0];

  // Normal bit15 is a live summary of the error register, so it is never stored or cleared.
  always_comb begin
    nis_set                       = normal_interrupt_status_i;
    nis_set[NIS_CMD_COMPLETE_BIT] = normal_interrupt_status_i[NIS_CMD_COMPLETE_BIT] | cmd_rise;
    nis_set[NIS_ERROR_BIT]        = 1'b0;
    nis_clr                       = 16'h0000;
    if (wr_vld && (adr_i == ADR_NORMAL_INT_STATUS)) begin
      nis_clr = wr_dat[15:0];
    end
    nis_clr[NIS_ERROR_BIT]        = 1'b0;
    eis_clr                       = 16'h0000;
    if (wr_vld && (adr_i == ADR_ERROR_INT_STATUS)) begin
      eis_clr = wr_dat[15:0];
    end
    nis_rd                        = nis_q;
    nis_rd[NIS_ERROR_BIT]         = |eis_q;
  end

  sd_w1c_status16 u_normal_status (
    .clock   (clock),
    .reset   (reset),
    .set_vec (nis_set),
    .clr_vec (nis_clr),
    .sw_clr  (sw_reset),
    .status  (nis_q)
  );

  sd_w1c_status16 u_error_status (
    .clock   (clock),
    .reset   (reset),
    .set_vec (error_interrupt_status_i),
    .clr_vec (eis_clr),
    .sw_clr  (sw_reset),
    .status  (eis_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      argument_o  <= 32'h0;
      command_o   <= 16'h0;
      block_q     <= 32'h0;
      host_ctrl_q <= 8'h0;
      clk_ctrl_q  <= 16'h0;
      int_en_q    <= 32'h0;
    end else if (wr_vld) begin
      case (adr_i)
        ADR_ARGUMENT:      argument_o  <= wr_dat;
        ADR_COMMAND:       if (!cmd_inhibit_q) command_o <= wr_dat[15:0];
        ADR_BLOCK:         block_q     <= wr_dat & BLOCK_WR_MASK;
        ADR_HOST_CONTROL:  host_ctrl_q <= wr_dat[7:0];
        ADR_CLOCK_CONTROL: clk_ctrl_q  <= wr_dat[15:0];
        ADR_INT_ENABLE:    int_en_q    <= wr_dat;
        default: ;
      endcase
    end
  end

  // A new command wins over a completion landing on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_complete_q <= 1'b0;
      cmd_inhibit_q  <= 1'b0;
      cmd_start_o    <= 1'b0;
      resp_q         <= 128'h0;
    end else begin
      cmd_complete_q <= command_complete;
      cmd_start_o    <= cmd_accept;
      if (sw_reset) begin
        cmd_inhibit_q <= 1'b0;
        resp_q        <= 128'h0;
      end else begin
        if (cmd_accept) begin
          cmd_inhibit_q <= 1'b1;
        end else if (cmd_rise) begin
          cmd_inhibit_q <= 1'b0;
        end
        if (cmd_rise) begin
          resp_q <= response_i;
        end
      end
    end
  end

  always_comb begin
    present_state                  = 32'h0;
    present_state[CMD_INHIBIT_BIT] = cmd_inhibit_q;
    rd_dat                         = RESERVED_RD_VAL;
    if (adr_impl) begin
      case (adr_i)
        ADR_ARGUMENT:          rd_dat = argument_o;
        ADR_COMMAND:           rd_dat = {16'h0, command_o};
        ADR_BLOCK:             rd_dat = block_q;
        ADR_PRESENT_STATE:     rd_dat = present_state;
        ADR_RESPONSE0:         rd_dat = resp_q[31:0];
        ADR_RESPONSE1:         rd_dat = resp_q[63:32];
        ADR_RESPONSE2:         rd_dat = resp_q[95:64];
        ADR_RESPONSE3:         rd_dat = resp_q[127:96];
        ADR_HOST_CONTROL:      rd_dat = {24'h0, host_ctrl_q};
        ADR_CLOCK_CONTROL:     rd_dat = {16'h0, clk_ctrl_q};
        ADR_NORMAL_INT_STATUS: rd_dat = {16'h0, nis_rd};
        ADR_ERROR_INT_STATUS:  rd_dat = {16'h0, eis_q};
        ADR_INT_ENABLE:        rd_dat = int_en_q;
        ADR_CAPABILITIES:      rd_dat = CAPABILITIES;
        default:               rd_dat = RESERVED_RD_VAL;
      endcase
    end
  end

  // Reads sample the pre-write state, so a same-edge write is not yet visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_o       <= 32'h0;
      read_valid_o <= 1'b0;
      interrupt_o  <= 1'b0;
    end else begin
      read_valid_o <= reg_read_en;
      if (reg_read_en) begin
        data_o <= rd_dat;
      end
      interrupt_o <= (|(nis_rd & int_en_q[15:0])) | (|(eis_q & int_en_q[31:16]));
    end
  end

endmodule
